seq_detector: RTL and testbench
===============================

# seq_detector

Serial bit-stream pattern detector for the fixed pattern "1011", MSB-first in arrival order. It samples one input bit per clock and raises a one-cycle flag each time the four most recent bits equal 1,0,1,1. Overlapping occurrences are detected. It sits directly on a synchronous serial data line and feeds a single-bit event output to downstream control logic.

## Interface
Parameters:
- None. The pattern "1011" and its length of 4 are fixed.

Ports:
- clk  input  1  single clock; all state updates occur on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
  - rst=0 forces reset immediately, independent of clk.
  - Release (0→1) takes effect on the following rising edges.
- din  input  1  serial data bit, sampled on each rising edge of clk. Must meet setup/hold to clk; benches drive it on the falling edge.
- dout  output  1  detect flag.
  - High for exactly one clock period after "1011" completes.
  - Driven from state register only (Moore); no combinational path from din.

## Operation
- Moore FSM with 5 states, binary-encoded in a 3-bit state register:
  - IDLE: no useful prefix.
  - S1: "1" matched.
  - S10: "10" matched.
  - S101: "101" matched.
  - DET: "1011" matched.
- Transitions on each rising edge, listed as (din=0 → next, din=1 → next):
  - IDLE: 0→IDLE, 1→S1.
  - S1: 0→S10, 1→S1.
  - S10: 0→IDLE, 1→S101.
  - S101: 0→S10, 1→DET.
  - DET: 0→S10, 1→S1. The trailing "1" is reused as a prefix, which gives overlap detection.
- Output decoding:
  - dout=1 only in DET; 0 in all other states.
  - Output is a registered flop or a decode of the state register; it must be glitch-free.
- Unused state encodings (3'b101–3'b111) go to IDLE on the next edge with dout=0.
- Reset:
  - While rst=0: state=IDLE and dout=0, asynchronously.
  - A partial match in progress is discarded.
  - No bits are sampled while rst=0.

## Timing
- Latency: dout rises on the same rising edge that samples the 4th pattern bit, i.e. visible one clock after that bit is presented. It falls on the next rising edge unless that edge completes another match.
- Back-to-back matches:
  - The minimum spacing between pulses is 3 cycles (stream 1011011).
  - Two consecutive dout=1 cycles are impossible.
- Reset:
  - The first sample after reset release is taken on the first rising edge with rst=1.
  - Reset asserted mid-pattern causes no detection from bits before the reset.
- No handshake or enable. Every rising edge out of reset consumes one bit.

## Test plan
- Reset: hold rst=0 over 2 edges with din toggling → dout=0, state IDLE. Assert rst=0 asynchronously between edges → dout drops immediately.
- Basic match: after release, drive din 1,0,1,1 on 4 successive edges → dout=1 for exactly the cycle after edge 4, 0 otherwise.
- Repeat: stream 1,0,1,1,1,0,1,1 → dout pulses after edges 4 and 8 only.
- Overlap: stream 1,0,1,1,0,1,1 → pulses after edges 4 and 7.
- Prefix recovery: stream 1,1,0,1,1 → single pulse after edge 5. Stream 1,0,0,1,0,1,1 → single pulse after edge 7. Streams 1,0,1,0 and 0,0,0,0 → no pulse.
- Reset mid-pattern: drive 1,0,1, pulse rst=0, release, then drive 1 → no pulse. Then drive 0,1,1 → pulse after the 4th post-reset edge.

Source files
------------

// File: rtl/seq_detector.sv
// seq_detector: serial "1011" pattern detector.
// Samples one bit of din per rising clk edge and raises dout for exactly one
// clock period each time the four most recent bits are 1,0,1,1. Overlapping
// occurrences are detected because the trailing "1" of a match is reused as
// the first bit of the next candidate. dout comes straight from a flop, so it
// is glitch-free and has no combinational path from din.

module seq_detector (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    // Binary-encoded match progress; codes 3'b101..3'b111 are unused.
    typedef enum logic [2:0] {
        IDLE = 3'd0,  // no useful prefix
        S1   = 3'd1,  // "1" matched
        S10  = 3'd2,  // "10" matched
        S101 = 3'd3,  // "101" matched
        DET  = 3'd4   // "1011" matched
    } state_t;

    state_t state;

    // Next-state table. Unused encodings fall back to IDLE so the FSM cannot
    // get stuck after an upset.
    function automatic state_t next_state(input state_t cur, input logic bit_in);
        state_t nxt;
        nxt = IDLE;
        case (cur)
            IDLE:    nxt = bit_in ? S1   : IDLE;
            S1:      nxt = bit_in ? S1   : S10;
            S10:     nxt = bit_in ? S101 : IDLE;
            S101:    nxt = bit_in ? DET  : S10;
            DET:     nxt = bit_in ? S1   : S10;  // trailing "1" restarts a match
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    // Advance the FSM one bit per edge and register the detect flag so it is
    // high exactly while the state register holds DET.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            dout  <= 1'b0;
        end else begin
            // NOTE: both registers use non-blocking assignments so they update
            // together from the same pre-edge values; blocking here would make
            // the result depend on statement order.
            state <= next_state(state, din);
            dout  <= (next_state(state, din) == DET);
        end
    end

endmodule

// File: tb/tb_seq_detector.sv
// Directed testbench for seq_detector. din is driven on the falling edge and
// dout is sampled 1 time unit after each rising edge.

module tb_seq_detector;

    logic clk;
    logic rst;
    logic din;
    logic dout;

    int checks   = 0;
    int failures = 0;

    seq_detector dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one bit on the falling edge, then move to just after the
    // rising edge that samples it.
    task automatic step(input logic b);
        @(negedge clk);
        din = b;
        @(posedge clk);
        #1;
    endtask

    // Put the DUT in a clean state; released on a falling edge so the next
    // rising edge takes the first sample.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        din = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        // Hold reset over two edges with din toggling.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            din = ~din;
            @(posedge clk);
            #1;
            checks++;
            if (dout !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold edge %0d: dout=%b expected=0", i, dout);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        // Reach DET, then assert reset between edges: dout must drop at once.
        step(1'b1); step(1'b0); step(1'b1); step(1'b1);
        checks++;
        if (dout !== 1'b1) begin
            failures++;
            $display("FAIL reset_async_pre: dout=%b expected=1", dout);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (dout !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: dout=%b expected=0", dout);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [4:0] bits = 5'b10110;
        logic [4:0] exp  = 5'b00010;
        do_reset();
        for (int i = 4; i >= 0; i--) begin
            step(bits[i]);
            checks++;
            if (dout !== exp[i]) begin
                failures++;
                $display("FAIL basic step %0d: dout=%b expected=%b", 4 - i, dout, exp[i]);
            end
        end
    endtask

    task automatic test_repeat();
        logic [7:0] bits = 8'b10111011;
        logic [7:0] exp  = 8'b00010001;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            step(bits[i]);
            checks++;
            if (dout !== exp[i]) begin
                failures++;
                $display("FAIL repeat step %0d: dout=%b expected=%b", 7 - i, dout, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Overlap at minimum spacing, then a trailing 1 must not extend the pulse.
        logic [7:0] bits = 8'b10110111;
        logic [7:0] exp  = 8'b00010010;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            step(bits[i]);
            checks++;
            if (dout !== exp[i]) begin
                failures++;
                $display("FAIL overlap step %0d: dout=%b expected=%b", 7 - i, dout, exp[i]);
            end
        end
    endtask

    task automatic test_prefix();
        logic [4:0]  bits_a = 5'b11011;
        logic [4:0]  exp_a  = 5'b00001;
        logic [6:0]  bits_b = 7'b1001011;
        logic [6:0]  exp_b  = 7'b0000001;
        logic [11:0] bits_c = 12'b1010_0000_1111;
        do_reset();
        for (int i = 4; i >= 0; i--) begin
            step(bits_a[i]);
            checks++;
            if (dout !== exp_a[i]) begin
                failures++;
                $display("FAIL prefix_11011 step %0d: dout=%b expected=%b", 4 - i, dout, exp_a[i]);
            end
        end
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            step(bits_b[i]);
            checks++;
            if (dout !== exp_b[i]) begin
                failures++;
                $display("FAIL prefix_1001011 step %0d: dout=%b expected=%b", 6 - i, dout, exp_b[i]);
            end
        end
        // 1010, 0000 and a run of ones: never a pulse.
        do_reset();
        for (int i = 11; i >= 0; i--) begin
            step(bits_c[i]);
            checks++;
            if (dout !== 1'b0) begin
                failures++;
                $display("FAIL no_match step %0d: dout=%b expected=0", 11 - i, dout);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp = 4'b0001;
        do_reset();
        step(1'b1); step(1'b0); step(1'b1);
        do_reset();
        // Post-reset stream 1,0,1,1: only the 4th edge completes a match.
        for (int i = 3; i >= 0; i--) begin
            step(i == 2 ? 1'b0 : 1'b1);
            checks++;
            if (dout !== exp[i]) begin
                failures++;
                $display("FAIL reset_mid step %0d: dout=%b expected=%b", 3 - i, dout, exp[i]);
            end
        end
    endtask

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        din = 1'b0;
        test_reset();
        test_basic();
        test_repeat();
        test_back_to_back();
        test_prefix();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
